// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state encoding and default core geometry.
package core_pkg;

  // Sequencer state encoding, visible to software through fsm_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STALL  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_e;

  // Default geometry shared by the core and its execution units.
  localparam int DEF_STAGES = 4;
  localparam int DEF_UNITS  = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for sequencer performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!Reset) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: stage counter, stall, halt and watchdog
// control, plus saturating performance counters.
module stage_sequencer
  import core_pkg::*;
#(
  parameter  int STAGES     = DEF_STAGES,
  parameter  int UNITS      = DEF_UNITS,
  parameter  int EXEC_STAGE = 2,
  parameter  int TIMEOUT    = 255,
  parameter  int CNT_W      = 32,
  localparam int SW         = $clog2(STAGES),
  localparam int UW         = (UNITS > 1) ? $clog2(UNITS) : 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              run,
  input  logic              halt_req,
  input  logic [UNITS-1:0]  unit_busy,
  output logic [SW-1:0]     stage,
  output logic [STAGES-1:0] stage_onehot,
  output logic              stage_enable,
  output logic              exec_start,
  output logic              retire,
  output logic [2:0]        fsm_state,
  output logic              timeout_err,
  output logic [UW-1:0]     timeout_unit,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  stall_count
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int   WD_W         = $clog2(TIMEOUT + 1);
  localparam logic EXEC_AT_ZERO = (EXEC_STAGE == 0);

  seq_state_e      state;
  logic            halt_pend;
  logic [WD_W-1:0] wd_cnt;
  logic            any_busy;
  logic            active;
  logic [SW-1:0]   stage_next;
  logic [UW-1:0]   low_idx;

  assign any_busy     = |unit_busy;
  assign active       = (state == ST_RUN) || (state == ST_STALL);
  assign stage_enable = active && !any_busy;
  assign retire       = stage_enable && (stage == SW'(STAGES - 1));
  assign stage_next   = (stage == SW'(STAGES - 1)) ? '0 : stage + SW'(1);
  assign fsm_state    = state;

  // Lowest-numbered busy unit, captured when the watchdog fires.
  always_comb begin
    // NOTE: default first so no path through the loop leaves low_idx unassigned (no latch).
    low_idx = '0;
    for (int i = UNITS - 1; i >= 0; i--) begin
      if (unit_busy[i]) low_idx = UW'(i);
    end
  end

  // One-hot stage decode, blanked whenever the sequencer is not running.
  always_comb begin
    stage_onehot = '0;
    if (active) stage_onehot[stage] = 1'b1;
  end

  // Sequencer state machine with its registered outputs and watchdog.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      stage        <= '0;
      halt_pend    <= 1'b0;
      wd_cnt       <= '0;
      exec_start   <= 1'b0;
      timeout_err  <= 1'b0;
      timeout_unit <= '0;
    end else begin
      exec_start <= 1'b0;
      if (!any_busy) wd_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (halt_req) halt_pend <= 1'b1;
          if (run) begin
            state      <= ST_RUN;
            stage      <= '0;
            exec_start <= EXEC_AT_ZERO;
          end
        end
        ST_RUN, ST_STALL: begin
          if (any_busy) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              state        <= ST_ERROR;
              timeout_err  <= 1'b1;
              timeout_unit <= low_idx;
            end else begin
              state  <= ST_STALL;
              wd_cnt <= wd_cnt + WD_W'(1);
              if (halt_req) halt_pend <= 1'b1;
            end
          end else if (retire && (halt_pend || halt_req)) begin
            // Halt only lands on an instruction boundary.
            state     <= ST_HALTED;
            stage     <= '0;
            halt_pend <= 1'b0;
          end else begin
            state      <= ST_RUN;
            stage      <= stage_next;
            exec_start <= (stage_next == SW'(EXEC_STAGE));
            if (halt_req) halt_pend <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (run) begin
            state      <= ST_RUN;
            stage      <= '0;
            exec_start <= EXEC_AT_ZERO;
          end
        end
        default: begin
          // ERROR holds everything until reset.
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (active),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (retire),
    .q     (retire_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (active && any_busy),
    .q     (stall_count)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_stage_sequencer;

  localparam int S  = 4;
  localparam int U  = 3;
  localparam int EX = 2;
  localparam int TO = 8;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic [2:0]  unit_busy;

  logic [1:0]  stage, s_stage;
  logic [3:0]  stage_onehot, s_stage_onehot;
  logic        stage_enable, s_stage_enable;
  logic        exec_start, s_exec_start;
  logic        retire, s_retire;
  logic [2:0]  fsm_state, s_fsm_state;
  logic        timeout_err, s_timeout_err;
  logic [1:0]  timeout_unit, s_timeout_unit;
  logic [31:0] cycle_count, retire_count, stall_count;
  logic [3:0]  s_cycle_count, s_retire_count, s_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  stage_sequencer #(.STAGES(S), .UNITS(U), .EXEC_STAGE(EX), .TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(clk), .Reset(reset_n), .run(run), .halt_req(halt_req), .unit_busy(unit_busy),
    .stage(stage), .stage_onehot(stage_onehot), .stage_enable(stage_enable),
    .exec_start(exec_start), .retire(retire), .fsm_state(fsm_state),
    .timeout_err(timeout_err), .timeout_unit(timeout_unit), .cycle_count(cycle_count),
    .retire_count(retire_count), .stall_count(stall_count)
  );

  stage_sequencer #(.STAGES(S), .UNITS(U), .EXEC_STAGE(EX), .TIMEOUT(TO), .CNT_W(4)) dut_sat (
    .CLK(clk), .Reset(reset_n), .run(run), .halt_req(halt_req), .unit_busy(unit_busy),
    .stage(s_stage), .stage_onehot(s_stage_onehot), .stage_enable(s_stage_enable),
    .exec_start(s_exec_start), .retire(s_retire), .fsm_state(s_fsm_state),
    .timeout_err(s_timeout_err), .timeout_unit(s_timeout_unit), .cycle_count(s_cycle_count),
    .retire_count(s_retire_count), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode uses the documented state codes
  // (0 idle, 1 run, 2 stall, 3 halted, 4 error).
  int m_mode, m_stage, m_brun, m_tunit;
  bit m_pend, m_terr, m_exec;
  longint unsigned m_cyc, m_ret, m_stl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int lowest(input logic [2:0] b);
    for (int i = 0; i < 3; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_stage = 0; m_brun = 0; m_tunit = 0;
    m_pend = 0; m_terr = 0; m_exec = 0;
    m_cyc = 0; m_ret = 0; m_stl = 0;
  endtask

  task automatic model_step(input logic r, input logic rn, input logic h, input logic [2:0] b);
    int old_mode, old_stage;
    old_mode  = m_mode;
    old_stage = m_stage;
    if (!r) begin
      model_reset();
      return;
    end
    if (b == 3'b000) m_brun = 0;
    case (m_mode)
      0: begin
        if (h) m_pend = 1;
        if (rn) begin m_mode = 1; m_stage = 0; end
      end
      1, 2: begin
        m_cyc++;
        if (b != 3'b000) begin
          m_stl++;
          m_brun++;
          if (m_brun == TO) begin
            m_mode = 4; m_terr = 1; m_tunit = lowest(b);
          end else begin
            m_mode = 2;
            if (h) m_pend = 1;
          end
        end else if (m_stage == S - 1) begin
          m_ret++;
          m_stage = 0;
          if (m_pend || h) begin
            m_mode = 3; m_pend = 0;
          end else begin
            m_mode = 1;
          end
        end else begin
          m_mode = 1;
          m_stage++;
          if (h) m_pend = 1;
        end
        if (m_mode == 1 && m_stage == 0 && h) m_pend = 1;
      end
      3: if (rn) begin m_mode = 1; m_stage = 0; end
      default: ;
    endcase
    m_exec = (m_mode == 1) && (m_stage == EX) &&
             ((old_stage != EX) || old_mode == 0 || old_mode == 3);
  endtask

  task automatic compare_model();
    bit act, en, ret;
    logic [3:0] oh;
    act = (m_mode == 1) || (m_mode == 2);
    en  = act && (unit_busy == 3'b000);
    ret = en && (m_stage == S - 1);
    oh  = act ? (4'b0001 << m_stage) : 4'b0000;
    check("fsm_state", fsm_state, m_mode);
    check("stage", stage, m_stage);
    check("stage_onehot", stage_onehot, oh);
    check("stage_enable", stage_enable, en);
    check("retire", retire, ret);
    check("exec_start", exec_start, m_exec);
    check("timeout_err", timeout_err, m_terr);
    check("timeout_unit", timeout_unit, m_tunit);
    check("cycle_count", cycle_count, sat(m_cyc, 32));
    check("retire_count", retire_count, sat(m_ret, 32));
    check("stall_count", stall_count, sat(m_stl, 32));
    check("sat_cycle_count", s_cycle_count, sat(m_cyc, 4));
    check("sat_retire_count", s_retire_count, sat(m_ret, 4));
    check("sat_stall_count", s_stall_count, sat(m_stl, 4));
  endtask

  task automatic set_inputs(input logic r, input logic rn, input logic h, input logic [2:0] b);
    reset_n = r; run = rn; halt_req = h; unit_busy = b;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step(reset_n, run, halt_req, unit_busy);
    #1;
  endtask

  task automatic do_cycle(input logic r, input logic rn, input logic h, input logic [2:0] b);
    set_inputs(r, rn, h, b);
    @(negedge clk);
    compare_model();
    edge_step();
  endtask

  typedef struct {
    logic       rst, rn, h;
    logic [2:0] busy;
    int         st, stg;
    logic       en, ret, ex;
  } vec_t;

  vec_t tbl[11];

  int n_ex, n_busy, burst;
  logic [2:0] burst_pat, rb;
  logic rr, rrn, rh;

  initial begin
    // Run into stage 2, stall there for 5 cycles starting with exec_start.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'b100, 1, 2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b100, 2, 2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b100, 2, 2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b100, 2, 2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b100, 2, 2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2, 2, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 3, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 0, 1'b1, 1'b0, 1'b0};

    set_inputs(1'b0, 1'b0, 1'b0, 3'b000);
    model_reset();
    @(posedge clk);
    #1;
    do_cycle(1'b0, 1'b0, 1'b0, 3'b000);

    // Directed table with stall at the execute stage.
    n_ex = 0;
    for (int i = 0; i < 11; i++) begin
      set_inputs(tbl[i].rst, tbl[i].rn, tbl[i].h, tbl[i].busy);
      @(negedge clk);
      check($sformatf("tbl%0d_state", i), fsm_state, tbl[i].st);
      check($sformatf("tbl%0d_stage", i), stage, tbl[i].stg);
      check($sformatf("tbl%0d_enable", i), stage_enable, tbl[i].en);
      check($sformatf("tbl%0d_retire", i), retire, tbl[i].ret);
      check($sformatf("tbl%0d_exec", i), exec_start, tbl[i].ex);
      if (exec_start) n_ex++;
      compare_model();
      edge_step();
    end
    check("stall_exec_pulses", n_ex, 1);
    check("stall_stall_count", stall_count, 5);
    check("stall_retire_count", retire_count, 1);
    check("stall_cycle_count", cycle_count, 10);

    // Free run: 40 cycles, one retire every 4.
    do_cycle(1'b0, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b1, 1'b0, 3'b000);
    repeat (40) do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    check("free_retire_count", retire_count, 10);
    check("free_stall_count", stall_count, 0);
    check("free_cycle_count", cycle_count, 40);
    check("free_stage_wrap", stage, 0);
    check("free_sat_retire", s_retire_count, 10);

    // Halt requested in stage 1 completes the instruction first.
    do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b1, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    check("halt_state", fsm_state, 3);
    check("halt_stage", stage, 0);
    check("halt_retire_count", retire_count, 11);
    do_cycle(1'b1, 1'b0, 1'b1, 3'b000);
    check("halted_ignores_halt", fsm_state, 3);
    do_cycle(1'b1, 1'b1, 1'b0, 3'b000);
    check("resume_state", fsm_state, 1);
    check("resume_stage", stage, 0);
    repeat (4) do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    check("resume_no_stale_halt", fsm_state, 1);

    // Saturation of the 4-bit counters.
    repeat (40) do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    check("sat_retire_held", s_retire_count, 4'hF);
    check("wide_retire_count", retire_count, 22);
    repeat (8) do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    check("sat_retire_still_held", s_retire_count, 4'hF);

    // Reset in the middle of a stall.
    do_cycle(1'b0, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b1, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b000);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b100);
    do_cycle(1'b1, 1'b0, 1'b0, 3'b100);
    check("midstall_state", fsm_state, 2);
    check("midstall_stage", stage, 2);
    do_cycle(1'b0, 1'b0, 1'b0, 3'b100);
    check("rst_state", fsm_state, 0);
    check("rst_stage", stage, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_retire_count", retire_count, 0);
    check("rst_stall_count", stall_count, 0);

    // Watchdog: busy held, error after exactly TIMEOUT busy cycles.
    do_cycle(1'b1, 1'b1, 1'b0, 3'b000);
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 3'b110);
      n_busy++;
      if (fsm_state == 3'd4) break;
    end
    check("wd_busy_cycles", n_busy, TO);
    check("wd_state", fsm_state, 4);
    check("wd_err", timeout_err, 1);
    check("wd_unit", timeout_unit, 1);
    check("wd_stage_frozen", stage, 0);
    repeat (3) do_cycle(1'b1, 1'b1, 1'b0, 3'b000);
    check("wd_run_ignored", fsm_state, 4);
    do_cycle(1'b0, 1'b0, 1'b0, 3'b000);
    check("wd_reset_state", fsm_state, 0);
    check("wd_reset_err", timeout_err, 0);

    // Randomized traffic against the model.
    burst = 0;
    burst_pat = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 99) != 0);
      rrn = ($urandom_range(0, 7) == 0);
      rh  = ($urandom_range(0, 15) == 0);
      if (burst > 0) begin
        rb = burst_pat;
        burst--;
      end else if ($urandom_range(0, 19) == 0) begin
        burst_pat = 3'($urandom_range(1, 7));
        burst = $urandom_range(1, 11);
        rb = burst_pat;
      end else begin
        rb = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      do_cycle(rr, rrn, rh, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
